cpu_mem_responder: RTL

//  Memory-side responder for the cpu core's fetch and data interface. It returns the

---
 rtl/cpu_mem_responder.sv | 93 +++++++++
 1 files changed

// File: rtl/cpu_mem_responder.sv
// Unified word-addressed instruction/data RAM for the cpu core.
// Clears itself after every reset, then serves fetches, loads and stores.
module cpu_mem_responder #(
    parameter int                 WIDTH      = 32,
    parameter int                 DEPTH_LOG2 = 8,
    parameter logic [WIDTH-1:0]   NOP_INST   = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] inst,
    input  logic [WIDTH-1:0] address,
    input  logic [WIDTH-1:0] d,
    input  logic             read_n_write,
    output logic [WIDTH-1:0] rdata,
    output logic             busy,
    output logic             err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t                  state, state_next;
    logic [DEPTH_LOG2-1:0]   clear_idx, clear_idx_next;
    logic [WIDTH-1:0]        mem [DEPTH];

    logic [DEPTH_LOG2-1:0]   pc_idx, addr_idx;
    logic                    pc_ok, addr_ok;
    logic                    store_en, violation;

    // An access is legal only when word aligned and inside the RAM window.
    assign pc_idx   = pc[DEPTH_LOG2+1:2];
    assign addr_idx = address[DEPTH_LOG2+1:2];
    assign pc_ok    = (pc[1:0] == 2'b00) && (pc[WIDTH-1:DEPTH_LOG2+2] == '0);
    assign addr_ok  = (address[1:0] == 2'b00) && (address[WIDTH-1:DEPTH_LOG2+2] == '0);

    always_comb begin
        state_next     = state;
        clear_idx_next = clear_idx;
        busy           = 1'b0;
        inst           = NOP_INST;
        rdata          = '0;
        store_en       = 1'b0;
        violation      = 1'b0;
        case (state)
            CLEAR: begin
                busy           = 1'b1;
                clear_idx_next = clear_idx + 1'b1;
                if (&clear_idx) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                inst      = pc_ok ? mem[pc_idx] : NOP_INST;
                rdata     = addr_ok ? mem[addr_idx] : '0;
                store_en  = !read_n_write && addr_ok;
                violation = !pc_ok || !addr_ok;
            end
            default: begin
                state_next     = CLEAR;
                clear_idx_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= CLEAR;
            clear_idx <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_next;
            clear_idx <= clear_idx_next;
            if (violation) begin
                err <= 1'b1;
            end
        end
    end

    // RAM has no reset of its own; the clear sweep owns the write port until RUN.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clear_idx] <= '0;
        end else if (store_en) begin
            mem[addr_idx] <= d;
        end
    end

endmodule
